// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ byte producers.
// Latches the granted byte, strobes the transmitter, and paces frames by counting baud ticks.
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned FRAME_TICKS = 10,
  parameter int unsigned GAP_TICKS   = 1,
  parameter int unsigned ID_W        = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ack,
  input  logic                   baud_tick,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  output logic                   busy,
  output logic [ID_W-1:0]        grant_id,
  output logic                   frame_done
);

  localparam int unsigned MAX_TICKS = (FRAME_TICKS > GAP_TICKS) ? FRAME_TICKS : GAP_TICKS;
  localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    GAP
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  tick_cnt;
  logic [ID_W-1:0]   last_grant;

  logic              pick_valid;
  logic [ID_W-1:0]   pick_idx;
  logic [7:0]        pick_data;
  int unsigned       cand;

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_data  = '0;
    cand       = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = (32'(last_grant) + off) % NUM_REQ;
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = ID_W'(cand);
        pick_data  = req_data[8*cand +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      req_ack    <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      busy       <= 1'b0;
      grant_id   <= '0;
      frame_done <= 1'b0;
      tick_cnt   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else begin
      req_ack    <= '0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            tx_data    <= pick_data;
            grant_id   <= pick_idx;
            last_grant <= pick_idx;
            req_ack    <= NUM_REQ'(1) << pick_idx;
            tx_start   <= 1'b1;
            busy       <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          if (baud_tick) begin
            tick_cnt <= CNT_W'(1);
            tx_start <= 1'b0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (baud_tick) begin
            if (tick_cnt == FRAME_LAST) begin
              tick_cnt <= '0;
              if (GAP_TICKS > 0) begin
                state <= GAP;
              end else begin
                state      <= IDLE;
                busy       <= 1'b0;
                frame_done <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (baud_tick) begin
            if (tick_cnt == GAP_LAST) begin
              tick_cnt   <= '0;
              state      <= IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model (remaining-tick countdown per frame).
module tb_uart_tx_scheduler;

  localparam int FRAME = 10;
  localparam int GAPT  = 1;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        baud_tick;
  logic [3:0]  req_ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic [1:0]  grant_id;
  logic        frame_done;

  logic [3:0]  req0;
  logic        tick0;
  logic [3:0]  req_ack0;
  logic        tx_start0;
  logic [7:0]  tx_data0;
  logic        busy0;
  logic [1:0]  grant_id0;
  logic        frame_done0;

  uart_tx_scheduler #(.NUM_REQ(4), .FRAME_TICKS(FRAME), .GAP_TICKS(GAPT), .ID_W(2)) u_dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_ack(req_ack),
    .baud_tick(baud_tick), .tx_start(tx_start), .tx_data(tx_data), .busy(busy),
    .grant_id(grant_id), .frame_done(frame_done)
  );

  uart_tx_scheduler #(.NUM_REQ(4), .FRAME_TICKS(FRAME), .GAP_TICKS(0), .ID_W(2)) u_dut_nogap (
    .clk(clk), .reset(reset), .req(req0), .req_data(req_data), .req_ack(req_ack0),
    .baud_tick(tick0), .tx_start(tx_start0), .tx_data(tx_data0), .busy(busy0),
    .grant_id(grant_id0), .frame_done(frame_done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: a granted frame owes FRAME+GAP ticks; the first owed tick also ends tx_start.
  bit         m_busy, m_start, m_done;
  int         m_left;
  logic [1:0] m_grant, m_last;
  logic [7:0] m_data;
  logic [3:0] m_ack;

  function automatic void model_reset();
    m_busy = 0; m_start = 0; m_done = 0; m_left = 0;
    m_grant = 2'd0; m_last = 2'd3; m_data = 8'h00; m_ack = 4'h0;
  endfunction

  function automatic void model_step();
    int  c;
    bit  found;
    m_ack  = 4'h0;
    m_done = 0;
    found  = 0;
    if (!m_busy) begin
      for (int k = 1; k <= 4; k++) begin
        c = (int'(m_last) + k) % 4;
        if (!found && req[c]) begin
          found   = 1;
          m_grant = 2'(c);
          m_last  = 2'(c);
          m_data  = req_data[8*c +: 8];
          m_ack   = 4'(1 << c);
        end
      end
      if (found) begin
        m_busy  = 1;
        m_start = 1;
        m_left  = FRAME + GAPT;
      end
    end else if (baud_tick) begin
      m_start = 0;
      m_left--;
      if (m_left == 0) begin
        m_busy = 0;
        m_done = 1;
      end
    end
  endfunction

  int obs_q[$];
  int done_cnt;
  int ticks_busy;
  int tick_phase;

  function automatic logic next_tick(input int period);
    tick_phase++;
    return (tick_phase % period) == 0;
  endfunction

  function automatic int ack_index(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (a[i]) return i;
    return -1;
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic [3:0] r, input logic t);
    req       = r;
    baud_tick = t;
    if (t && busy) ticks_busy++;
    @(posedge clk);
    model_step();
    #1;
    check("cycle", {busy, tx_start, req_ack, frame_done, grant_id, tx_data},
                   {m_busy, m_start, m_ack, m_done, m_grant, m_data});
    if (req_ack != 4'h0) obs_q.push_back(ack_index(req_ack));
    if (frame_done) done_cnt++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1 model_reset();
    check("reset", {busy, tx_start, req_ack, frame_done, grant_id, tx_data},
                   {m_busy, m_start, m_ack, m_done, m_grant, m_data});
    @(negedge clk);
    reset = 1'b1;
    obs_q.delete();
    done_cnt = 0;
    ticks_busy = 0;
    tick_phase = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int exp3[5] = '{0, 1, 2, 3, 0};
  int period;
  logic [3:0] rr;

  initial begin
    reset = 1'b0; req = '0; req_data = '0; baud_tick = 1'b0; req0 = '0; tick0 = 1'b0;
    done_cnt = 0; ticks_busy = 0; tick_phase = 0;
    model_reset();
    #23;
    check("rst_busy", busy, 1'b0);
    check("rst_start", tx_start, 1'b0);
    check("rst_ack", req_ack, 4'h0);
    check("rst_data", tx_data, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    // idle with no requests
    repeat (100) cycle(4'h0, next_tick(5));
    check("idle_acks", obs_q.size(), 0);
    check("idle_done", done_cnt, 0);

    // single requester 1, byte A5, tick every 16 clk
    req_data = {8'h3C, 8'h7E, 8'hA5, 8'h5A};
    tick_phase = 0;
    for (int i = 0; i < 400 && done_cnt == 0; i++)
      cycle((obs_q.size() != 0) ? 4'h0 : 4'b0010, next_tick(16));
    check("t2_done", done_cnt, 1);
    check("t2_acks", obs_q.size(), 1);
    check("t2_grant", (obs_q.size() > 0) ? obs_q[0] : -1, 1);
    check("t2_txdata", tx_data, 8'hA5);
    check("t2_grant_id", grant_id, 2'd1);
    check("t2_ticks", ticks_busy, FRAME + GAPT);

    // all requesting: strict rotation from 0
    do_reset();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 2000 && done_cnt < 5; i++) cycle(4'b1111, next_tick(3));
    check("t3_count", obs_q.size(), 5);
    for (int i = 0; i < 5; i++)
      check("t3_order", (i < obs_q.size()) ? obs_q[i] : -1, exp3[i]);

    // pointer wrap: after granting 2, requester 0 wins over 2
    do_reset();
    for (int i = 0; i < 500 && obs_q.size() < 2; i++)
      cycle((obs_q.size() == 0) ? 4'b0100 : 4'b0101, next_tick(2));
    check("t4_first", (obs_q.size() > 0) ? obs_q[0] : -1, 2);
    check("t4_wrap", (obs_q.size() > 1) ? obs_q[1] : -1, 0);

    // no-gap instance: tick during the grant cycle is ignored
    req0 = 4'b0001; tick0 = 1'b1;
    cycle(4'h0, 1'b0);
    check("t5_start", tx_start0, 1'b1);
    check("t5_busy", busy0, 1'b1);
    req0 = 4'h0; tick0 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      repeat (3) cycle(4'h0, 1'b0);
      tick0 = 1'b1;
      cycle(4'h0, 1'b0);
      tick0 = 1'b0;
      check("t5_done", frame_done0, k == 10);
    end
    check("t5_idle", busy0, 1'b0);

    // reset in the middle of a frame
    do_reset();
    req_data = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    for (int i = 0; i < 200 && ticks_busy < 5; i++) cycle(4'b0001, next_tick(4));
    check("t6_ticks", ticks_busy, 5);
    check("t6_busy_pre", busy, 1'b1);
    do_reset();
    repeat (20) cycle(4'h0, next_tick(4));
    check("t6_no_done", done_cnt, 0);
    for (int i = 0; i < 50 && obs_q.size() == 0; i++) cycle(4'b1001, next_tick(4));
    check("t6_grant", (obs_q.size() > 0) ? obs_q[0] : -1, 0);

    // randomized traffic; req changes mid-frame must be ignored
    do_reset();
    for (int seg = 0; seg < 150; seg++) begin
      period   = $urandom_range(1, 5);
      req_data = $urandom;
      rr       = 4'($urandom_range(0, 15));
      repeat (20) cycle(rr, next_tick(period));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
